// File: rtl/seven_seg_pkg.sv
// Shared types for the seven-segment scan controller.
package seven_seg_pkg;

  typedef logic [0:6] seg_t;
  typedef logic [3:0] hex_t;

  typedef enum logic {
    ST_ON,
    ST_DEAD
  } state_t;

  localparam seg_t SEG_BLANK = 7'b1111111;

  // Counter width that stays at least one bit for tiny ranges.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/decoder_7segments.sv
// Hex to active-low a..g segment decoder, common-anode display.
module decoder_7segments
  import seven_seg_pkg::*;
(
  input  hex_t hex,
  output seg_t seg
);

  always_comb begin
    seg = SEG_BLANK;
    unique case (hex)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      4'hF: seg = 7'b0111000;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed 7-seg scan controller with dead time between digits.
// Optional SEVEN_SEG_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [2:0]            wr_addr,
  input  logic [3:0]            wr_data,
  input  logic [NUM_DIGITS-1:0] blank,
  output seg_t                  seg_out,
  output logic [NUM_DIGITS-1:0] digit_sel_n,
  output logic                  frame_done
);

  localparam int IW = cnt_w(NUM_DIGITS);
  localparam int PW = cnt_w(REFRESH_DIV);
  localparam int DW = cnt_w(DEAD_CYCLES);

  hex_t            digit_reg [NUM_DIGITS];
  logic [IW-1:0]   idx_q;
  logic [PW-1:0]   pre_q;
  logic [DW-1:0]   dead_q;
  state_t          state_q;
  state_t          state_d;

  hex_t                  cur_hex;
  logic                  cur_blank;
  logic                  lz_blank;
  seg_t                  dec_seg;
  logic [NUM_DIGITS-1:0] sel_n_c;
  logic                  pre_end;
  logic                  dead_end;
  logic                  last_digit;

  assign pre_end    = pre_q == PW'(REFRESH_DIV - 1);
  assign dead_end   = dead_q == DW'(DEAD_CYCLES - 1);
  assign last_digit = idx_q == IW'(NUM_DIGITS - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++)
        digit_reg[i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_DIGITS; i++)
        if (wr_addr == 3'(i))
          digit_reg[i] <= wr_data;
    end
  end

  always_comb begin
    cur_hex   = '0;
    cur_blank = 1'b0;
    sel_n_c   = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_hex    = digit_reg[i];
        cur_blank  = blank[i];
        sel_n_c[i] = 1'b0;
      end
    end
  end

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  // Dark when this digit and every higher one hold zero; digit 0 never.
  always_comb begin
    lz_blank = idx_q != '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (IW'(i) >= idx_q && digit_reg[i] != '0)
        lz_blank = 1'b0;
  end
`else
  assign lz_blank = 1'b0;
`endif

  decoder_7segments u_dec (
    .hex (cur_hex),
    .seg (dec_seg)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_ON:   if (pre_end)  state_d = ST_DEAD;
      ST_DEAD: if (dead_end) state_d = ST_ON;
      default: state_d = ST_ON;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ON;
      idx_q   <= '0;
      pre_q   <= '0;
      dead_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_ON)
        pre_q <= pre_end ? '0 : pre_q + 1'b1;
      if (state_q == ST_DEAD) begin
        dead_q <= dead_end ? '0 : dead_q + 1'b1;
        if (dead_end)
          idx_q <= last_digit ? '0 : idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_out     <= SEG_BLANK;
      digit_sel_n <= '1;
      frame_done  <= 1'b0;
    end else if (state_q == ST_ON) begin
      seg_out     <= (cur_blank || lz_blank) ? SEG_BLANK : dec_seg;
      digit_sel_n <= sel_n_c;
      frame_done  <= pre_end && last_digit;
    end else begin
      seg_out     <= SEG_BLANK;
      digit_sel_n <= '1;
      frame_done  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench for seven_seg_scan_ctrl (4 digits, div 4, dead 1).
module tb_seven_seg_scan_ctrl;
  import seven_seg_pkg::*;

  localparam int N = 4;
  localparam int R = 4;
  localparam int D = 1;
  localparam int P = R + D;
  localparam int F = N * P;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         wr_en = 1'b0;
  logic [2:0]   wr_addr = '0;
  logic [3:0]   wr_data = '0;
  logic [N-1:0] blank = '0;
  seg_t         seg_out;
  logic [N-1:0] digit_sel_n;
  logic         frame_done;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS  (N),
    .REFRESH_DIV (R),
    .DEAD_CYCLES (D)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .blank       (blank),
    .seg_out     (seg_out),
    .digit_sel_n (digit_sel_n),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] val;
    logic [6:0] seg;
  } vec_t;

  vec_t tbl [16];
  int n_cmp = 0;
  int n_bad = 0;
  int t = 0;
  logic [3:0] m_dig [N];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: time since release fixes digit and lit/dark phase.
  task automatic tick();
    int pos, idx, ph;
    logic lz;
    logic [6:0] e_seg;
    logic [N-1:0] e_sel;
    logic e_fd;
    pos = t % F;
    idx = pos / P;
    ph  = pos % P;
    lz  = 1'b0;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    if (idx > 0) begin
      lz = 1'b1;
      for (int j = idx; j < N; j++)
        if (m_dig[j] != 0) lz = 1'b0;
    end
`endif
    e_sel = '1;
    if (ph < R) begin
      e_seg = (blank[idx] || lz) ? 7'h7f : tbl[m_dig[idx]].seg;
      e_sel[idx] = 1'b0;
      e_fd = (ph == R - 1) && (idx == N - 1);
    end else begin
      e_seg = 7'h7f;
      e_fd  = 1'b0;
    end
    if (wr_en && int'(wr_addr) < N)
      m_dig[int'(wr_addr)] = wr_data;
    t++;
    @(posedge clk);
    #1;
    chk("seg", 32'(seg_out), 32'(e_seg));
    chk("sel", 32'(digit_sel_n), 32'(e_sel));
    chk("frame_done", 32'(frame_done), 32'(e_fd));
  endtask

  task automatic wr(input int a, input logic [3:0] d);
    wr_en   = 1'b1;
    wr_addr = 3'(a);
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_seg", 32'(seg_out), 32'h7f);
    chk("rst_sel", 32'(digit_sel_n), 32'hf);
    chk("rst_fd", 32'(frame_done), 32'h0);
    for (int i = 0; i < N; i++) m_dig[i] = '0;
    t = 0;
    @(posedge clk);
    #1;
    chk("rst_hold_sel", 32'(digit_sel_n), 32'hf);
    rst_n = 1'b1;
  endtask

  task automatic sync_to(input int p);
    int k;
    k = 0;
    while (t % F != p && k < F + 2) begin
      tick();
      k++;
    end
    if (t % F != p) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sync_to %0d: timeout", p);
    end
  endtask

  initial begin
    int fd_cnt, seen;
    bit found;
    tbl[0]  = '{4'h0, 7'b0000001};
    tbl[1]  = '{4'h1, 7'b1001111};
    tbl[2]  = '{4'h2, 7'b0010010};
    tbl[3]  = '{4'h3, 7'b0000110};
    tbl[4]  = '{4'h4, 7'b1001100};
    tbl[5]  = '{4'h5, 7'b0100100};
    tbl[6]  = '{4'h6, 7'b0100000};
    tbl[7]  = '{4'h7, 7'b0001111};
    tbl[8]  = '{4'h8, 7'b0000000};
    tbl[9]  = '{4'h9, 7'b0000100};
    tbl[10] = '{4'hA, 7'b0001000};
    tbl[11] = '{4'hB, 7'b1100000};
    tbl[12] = '{4'hC, 7'b0110001};
    tbl[13] = '{4'hD, 7'b1000010};
    tbl[14] = '{4'hE, 7'b0110000};
    tbl[15] = '{4'hF, 7'b0111000};

    #2;
    do_reset();
    tick();
    tick();
    chk("rel_sel", 32'(digit_sel_n), 32'he);
    chk("rel_seg", 32'(seg_out), 32'h01);

    for (int a = 0; a < N; a++) wr(a, 4'(a + 1));
    fd_cnt = 0;
    for (int k = 0; k < 2 * F; k++) begin
      tick();
      fd_cnt += int'(frame_done);
    end
    chk("fd_per_2_frames", 32'(fd_cnt), 32'd2);

    for (int i = 0; i < 16; i++) begin
      wr(0, tbl[i].val);
      found = 1'b0;
      for (int k = 0; k < F + 2 && !found; k++) begin
        tick();
        found = digit_sel_n == 4'b1110;
      end
      if (!found) begin
        n_cmp++;
        n_bad++;
        $display("FAIL tbl_wait %0d: digit 0 never lit", i);
      end else begin
        chk($sformatf("tbl_%0d", i), 32'(seg_out), 32'(tbl[i].seg));
      end
    end

    sync_to(0);
    tick();
    wr(0, 4'hA);
    chk("wr_lat_edge", 32'(seg_out), 32'(tbl[15].seg));
    tick();
    chk("wr_lat_next", 32'(seg_out), 32'h08);

    wr(5, 4'h7);
    for (int k = 0; k < F; k++) tick();

    blank = 4'b0100;
    seen = 0;
    for (int k = 0; k < F; k++) begin
      tick();
      if (digit_sel_n == 4'b1011) begin
        chk("blank2_seg", 32'(seg_out), 32'h7f);
        seen++;
      end
    end
    chk("blank2_lit_cycles", 32'(seen), 32'(R));
    blank = '0;

    sync_to(2 * P + 1);
    tick();
    chk("pre_rst_sel", 32'(digit_sel_n), 32'hb);
    do_reset();
    tick();
    tick();
    chk("post_rst_sel", 32'(digit_sel_n), 32'he);
    chk("post_rst_seg", 32'(seg_out), 32'h01);

    wr(0, 4'h0);
    wr(1, 4'h0);
    wr(2, 4'h3);
    wr(3, 4'h0);
    for (int k = 0; k < F; k++) begin
      tick();
      if (digit_sel_n == 4'b0111) begin
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        chk("lz_d3", 32'(seg_out), 32'h7f);
`else
        chk("lz_d3", 32'(seg_out), 32'h01);
`endif
      end
      if (digit_sel_n == 4'b1011)
        chk("lz_d2", 32'(seg_out), 32'h06);
    end

    for (int k = 0; k < 400; k++) begin
      wr_en   = $urandom_range(0, 2) == 0;
      wr_addr = 3'($urandom_range(0, 7));
      wr_data = 4'($urandom);
      if (k % 23 == 0) blank = N'($urandom);
      if (k == 200) begin
        wr_en = 1'b0;
        do_reset();
      end
      tick();
    end
    wr_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
